spi_obi_arb: RTL and testbench
==============================

# spi_obi_arb

Two-master OBI arbiter placed in front of the SPI peripheral's single OBI slave port. It lets the CPU data port (master 0) and the boot/DMA engine (master 1) share the SPI controller. Arbitration is round-robin. An optional per-master bus lock keeps multi-register SPI sequences atomic, and a lock timeout stops one master from starving the other. Responses are routed back in order through a small ID FIFO.

## Interface
Parameters:
- LOCK_TIMEOUT, default 1024: cycles a lock may be held while the other master waits. 0 disables the timeout.
- OUTSTANDING, default 2: ID FIFO depth, i.e. the maximum number of accepted-but-unanswered requests.

Ports:
- clk_i  in  1  clock. One clock domain only.
- rst_ni  in  1  reset, asynchronous, active-low.
- mN_req_i  in  1  request from master N (N = 0, 1).
- mN_we_i  in  1  write enable.
- mN_be_i  in  4  byte enables.
- mN_addr_i  in  32  address.
- mN_data_i  in  32  write data.
- mN_lock_i  in  1  hold bus ownership after the current grant.
- mN_gnt_o  out  1  grant. Combinational.
- mN_rvalid_o  out  1  response valid.
- mN_data_o  out  32  read data.
- s_req_o, s_we_o  out  1  request and write enable to the SPI slave.
- s_be_o  out  4  byte enables to the SPI slave.
- s_addr_o, s_data_o  out  32  address and write data to the SPI slave.
- s_gnt_i  in  1  slave grant.
- s_rvalid_i  in  1  slave response valid.
- s_data_i  in  32  slave read data.
- lock_timeout_o  out  1  one-cycle pulse when a lock is forcibly revoked.

## Operation
- Winner selection, per cycle:
  - If an owner is locked, only the owner is eligible.
  - Otherwise, if both masters request, the master named by the priority pointer wins. A lone requester wins.
- The slave request fields are muxed from the winner. s_req_o = winner_req & !fifo_full_eff.
  - fifo_full_eff = FIFO full and no pop in this cycle.
- Handshake: winner gnt_o = s_req_o & s_gnt_i. The loser's gnt_o = 0. On each handshake:
  - push the winner ID into the FIFO;
  - move the priority pointer to the other master.
- Response routing: s_rvalid_i pops the FIFO head ID. The master with that ID gets rvalid_o = 1 and data_o = s_data_i.
  - The other master gets rvalid_o = 0 and data_o = 0.
  - An s_rvalid_i that arrives with the FIFO empty is dropped, with no master rvalid.
- Lock:
  - A handshake with mN_lock_i = 1 sets owner = N, locked = 1.
  - locked clears on the first cycle the owner's lock_i = 0. A request in that same cycle is arbitrated unlocked.
- Timeout counter:
  - Increments each cycle that locked = 1 and the non-owner has req_i = 1.
  - Resets to 0 when the lock is released or taken.
  - When it reaches LOCK_TIMEOUT, the block clears locked, pulses lock_timeout_o, and sets the priority pointer to the non-owner.
  - The former owner's lock_i is then ignored until it goes low for at least one cycle.
- Simultaneous FIFO push and pop is legal in any fill state, including full.

## Timing
- Zero-latency request path: mN_* to s_* and s_gnt_i to mN_gnt_o are combinational.
- Zero-latency response path: s_rvalid_i/s_data_i to mN_rvalid_o/mN_data_o are combinational.
- With the SPI slave (gnt = req, rvalid one cycle later), each master sees rvalid exactly 1 cycle after its grant.
- Back-to-back alternating grants sustain one transaction per cycle.
- Reset values:
  - priority pointer = master 0; locked = 0; FIFO empty; timeout counter = 0.
  - lock_timeout_o = 0; all gnt, rvalid and s_req outputs = 0; data outputs = 0.
- Reset mid-operation drops all outstanding IDs. Responses arriving after reset are discarded, as with an empty FIFO.

## Structure
- Package spi_arb_pkg holds:
  - typedef mst_id_t (1 bit);
  - struct obi_req_t (we, be, addr, wdata);
  - constant default LOCK_TIMEOUT;
  - counter width, $clog2(LOCK_TIMEOUT+1).
- Sub-module spi_arb_id_fifo: OUTSTANDING-deep FIFO of mst_id_t with full/empty flags and simultaneous push/pop.
- The top level holds the arbitration logic, lock register, timeout counter and response mux.

## Test plan
- Only m0 reads addr 0x0004 while the slave returns 0xA5A5_0001 → m0_gnt_o same cycle, m0_rvalid_o the next cycle with 0xA5A5_0001, m1_rvalid_o stays 0.
- Both masters request continuously for 6 cycles after reset → grants alternate m0, m1, m0, m1, m0, m1, and each response is routed to its own master.
- m0 asserts lock with 4 writes while m1 requests → m1 gnt held 0 until m0_lock_i falls, then m1 is granted the next request cycle.
- LOCK_TIMEOUT=8, m0 holds lock forever, m1 requests → lock_timeout_o pulses on the 8th waiting cycle and m1 is granted. m0 then cannot re-lock until it drops lock_i.
- Slave with s_gnt_i=1 and rvalid delayed 3 cycles, OUTSTANDING=2 → a third request stalls (s_req_o=0) until the first rvalid; the push in the pop cycle is accepted.
- Spurious s_rvalid_i with the FIFO empty, and rst_ni pulsed with 2 outstanding → no master rvalid, and all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-master OBI arbiter in front of the SPI slave port.
package spi_arb_pkg;

  typedef logic mst_id_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  localparam int unsigned LockTimeoutDflt = 1024;

  // A zero timeout disables the counter, but it still needs one bit to be declarable.
  function automatic int unsigned lock_cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/spi_obi_arb_if.sv
// Bundle of both master OBI ports, the SPI slave OBI port and the lock timeout pulse.
interface spi_obi_arb_if;
  logic        m0_req_i;
  logic        m0_we_i;
  logic [3:0]  m0_be_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_data_i;
  logic        m0_lock_i;
  logic        m0_gnt_o;
  logic        m0_rvalid_o;
  logic [31:0] m0_data_o;

  logic        m1_req_i;
  logic        m1_we_i;
  logic [3:0]  m1_be_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_data_i;
  logic        m1_lock_i;
  logic        m1_gnt_o;
  logic        m1_rvalid_o;
  logic [31:0] m1_data_o;

  logic        s_req_o;
  logic        s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_data_o;
  logic        s_gnt_i;
  logic        s_rvalid_i;
  logic [31:0] s_data_i;

  logic        lock_timeout_o;

  modport arb (
    input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_data_i, m0_lock_i,
    output m0_gnt_o, m0_rvalid_o, m0_data_o,
    input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_data_i, m1_lock_i,
    output m1_gnt_o, m1_rvalid_o, m1_data_o,
    output s_req_o, s_we_o, s_be_o, s_addr_o, s_data_o,
    input  s_gnt_i, s_rvalid_i, s_data_i,
    output lock_timeout_o
  );

  modport env (
    output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_data_i, m0_lock_i,
    input  m0_gnt_o, m0_rvalid_o, m0_data_o,
    output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_data_i, m1_lock_i,
    input  m1_gnt_o, m1_rvalid_o, m1_data_o,
    input  s_req_o, s_we_o, s_be_o, s_addr_o, s_data_o,
    output s_gnt_i, s_rvalid_i, s_data_i,
    input  lock_timeout_o
  );
endinterface

// File: rtl/spi_arb_id_fifo.sv
// In-order FIFO of master IDs for accepted-but-unanswered requests; push and pop may coincide.
module spi_arb_id_fifo
  import spi_arb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  mst_id_t id_i,
  input  logic    pop_i,
  output mst_id_t id_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  mst_id_t         mem_q [Depth];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [CntW-1:0] cnt_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign id_o    = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_q] <= id_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_next(wr_q);
      if (do_pop)  rd_q <= ptr_next(rd_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/spi_obi_arb.sv
// Round-robin two-master OBI arbiter with per-master bus lock, lock timeout and in-order
// response routing for the SPI controller's single OBI slave port.
module spi_obi_arb
  import spi_arb_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = LockTimeoutDflt,
  parameter int unsigned OUTSTANDING  = 2
) (
  input logic        clk_i,
  input logic        rst_ni,
  spi_obi_arb_if.arb bus
);

  localparam int unsigned CntW = lock_cnt_width(LOCK_TIMEOUT);

  obi_req_t        mreq [2];
  obi_req_t        sel;
  logic [1:0]      req, lock_in, block_q;
  mst_id_t         win, owner_q, prio_q, head;
  logic            win_req, locked_q, locked_eff, wait_cyc, timeout_hit, timeout_q;
  logic            fifo_full, fifo_empty, pop, s_req, hs;
  logic [CntW-1:0] cnt_q, cnt_inc;

  assign mreq[0] = '{we: bus.m0_we_i, be: bus.m0_be_i, addr: bus.m0_addr_i,
                     wdata: bus.m0_data_i};
  assign mreq[1] = '{we: bus.m1_we_i, be: bus.m1_be_i, addr: bus.m1_addr_i,
                     wdata: bus.m1_data_i};
  assign req     = {bus.m1_req_i, bus.m0_req_i};
  // A master whose lock was revoked cannot re-lock until it drops lock_i once.
  assign lock_in = {bus.m1_lock_i, bus.m0_lock_i} & ~block_q;

  always_comb begin
    locked_eff = locked_q & lock_in[owner_q];
    if (locked_eff)          win = owner_q;
    else if (req[0] & req[1]) win = prio_q;
    else if (req[1])         win = 1'b1;
    else if (req[0])         win = 1'b0;
    else                     win = prio_q;
    win_req = req[win];
    sel     = win_req ? mreq[win] : '0;
  end

  assign pop         = bus.s_rvalid_i & ~fifo_empty;
  assign s_req       = win_req & ~(fifo_full & ~pop);
  assign hs          = s_req & bus.s_gnt_i;
  assign wait_cyc    = locked_eff & req[~owner_q];
  assign cnt_inc     = cnt_q + CntW'(1);
  assign timeout_hit = (LOCK_TIMEOUT != 0) && wait_cyc && (cnt_inc == CntW'(LOCK_TIMEOUT));

  assign bus.s_req_o        = s_req;
  assign bus.s_we_o         = sel.we;
  assign bus.s_be_o         = sel.be;
  assign bus.s_addr_o       = sel.addr;
  assign bus.s_data_o       = sel.wdata;
  assign bus.m0_gnt_o       = hs & (win == 1'b0);
  assign bus.m1_gnt_o       = hs & (win == 1'b1);
  assign bus.m0_rvalid_o    = pop & (head == 1'b0);
  assign bus.m1_rvalid_o    = pop & (head == 1'b1);
  assign bus.m0_data_o      = (pop && head == 1'b0) ? bus.s_data_i : '0;
  assign bus.m1_data_o      = (pop && head == 1'b1) ? bus.s_data_i : '0;
  assign bus.lock_timeout_o = timeout_q;

  spi_arb_id_fifo #(
    .Depth (OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs),
    .id_i    (win),
    .pop_i   (pop),
    .id_o    (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      locked_q  <= 1'b0;
      cnt_q     <= '0;
      block_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      block_q   <= block_q & {bus.m1_lock_i, bus.m0_lock_i};
      if (hs) prio_q <= ~win;
      if (locked_q && !lock_in[owner_q]) begin
        locked_q <= 1'b0;
        cnt_q    <= '0;
      end else if (wait_cyc) begin
        cnt_q <= cnt_inc;
      end
      if (hs && lock_in[win]) begin
        owner_q  <= win;
        locked_q <= 1'b1;
        if (!locked_eff) cnt_q <= '0;
      end
      // Revocation overrides any lock taken or renewed in the same cycle.
      if (timeout_hit) begin
        locked_q         <= 1'b0;
        cnt_q            <= '0;
        prio_q           <= ~owner_q;
        block_q[owner_q] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_obi_arb.sv
// Directed bench for spi_obi_arb; the slave side is driven by hand each cycle.
module tb_spi_obi_arb;

  logic clk = 1'b0;
  logic rst_ni;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  spi_obi_arb_if bus ();

  spi_obi_arb #(
    .LOCK_TIMEOUT (8),
    .OUTSTANDING  (2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic l0, input logic r1, input logic l1);
    bus.m0_req_i  = r0;
    bus.m0_lock_i = l0;
    bus.m1_req_i  = r1;
    bus.m1_lock_i = l1;
  endtask

  task automatic slv(input logic g, input logic rv, input logic [31:0] d);
    bus.s_gnt_i    = g;
    bus.s_rvalid_i = rv;
    bus.s_data_i   = d;
  endtask

  logic [15:0] t4_r0, t4_l0, t4_r1, t4_g0, t4_g1, t4_to;

  initial begin
    rst_ni        = 1'b0;
    bus.m0_we_i   = 1'b1;
    bus.m0_be_i   = 4'hF;
    bus.m0_addr_i = 32'h10;
    bus.m0_data_i = 32'hD0;
    bus.m1_we_i   = 1'b0;
    bus.m1_be_i   = 4'h3;
    bus.m1_addr_i = 32'h20;
    bus.m1_data_i = 32'hE0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    slv(1'b0, 1'b1, 32'hDEAD);
    repeat (2) @(posedge clk);
    #2;
    chkb("rst_g0", bus.m0_gnt_o, 1'b0);
    chkb("rst_g1", bus.m1_gnt_o, 1'b0);
    chkb("rst_sreq", bus.s_req_o, 1'b0);
    chkb("rst_rv0", bus.m0_rvalid_o, 1'b0);
    chkb("rst_rv1", bus.m1_rvalid_o, 1'b0);
    chk("rst_d0", bus.m0_data_o, 32'h0);
    chkb("rst_to", bus.lock_timeout_o, 1'b0);
    rst_ni = 1'b1;
    slv(1'b0, 1'b0, 32'h0);

    // Both masters request for 6 cycles: m0, m1 alternate; responses one cycle later.
    for (int k = 0; k < 7; k++) begin
      tick();
      drive(k < 6, 1'b0, k < 6, 1'b0);
      slv(1'b1, k > 0, 32'h100 + k);
      #1;
      if (k < 6) begin
        chkb("alt_g0", bus.m0_gnt_o, (k % 2) == 0);
        chkb("alt_g1", bus.m1_gnt_o, (k % 2) == 1);
        chk("alt_addr", bus.s_addr_o, ((k % 2) == 0) ? 32'h10 : 32'h20);
      end
      if (k > 0) begin
        chkb("alt_rv0", bus.m0_rvalid_o, ((k - 1) % 2) == 0);
        chkb("alt_rv1", bus.m1_rvalid_o, ((k - 1) % 2) == 1);
        if (((k - 1) % 2) == 0) chk("alt_d0", bus.m0_data_o, 32'h100 + k);
        else                    chk("alt_d1", bus.m1_data_o, 32'h100 + k);
      end
    end

    // Single m0 read of 0x4.
    tick();
    bus.m0_we_i   = 1'b0;
    bus.m0_addr_i = 32'h4;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    slv(1'b1, 1'b0, 32'h0);
    #1;
    chkb("rd_sreq", bus.s_req_o, 1'b1);
    chk("rd_addr", bus.s_addr_o, 32'h4);
    chkb("rd_we", bus.s_we_o, 1'b0);
    chkb("rd_g0", bus.m0_gnt_o, 1'b1);
    chkb("rd_g1", bus.m1_gnt_o, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    slv(1'b0, 1'b1, 32'hA5A5_0001);
    #1;
    chkb("rd_rv0", bus.m0_rvalid_o, 1'b1);
    chk("rd_d0", bus.m0_data_o, 32'hA5A5_0001);
    chkb("rd_rv1", bus.m1_rvalid_o, 1'b0);
    chk("rd_d1", bus.m1_data_o, 32'h0);

    // m0 locks for 4 writes; m1 waits until the lock drops.
    bus.m0_we_i   = 1'b1;
    bus.m0_addr_i = 32'h30;
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    slv(1'b1, 1'b0, 32'h0);
    #1;
    chkb("lk_g0_first", bus.m0_gnt_o, 1'b1);
    for (int i = 1; i < 4; i++) begin
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      slv(1'b1, 1'b1, 32'h200 + i);
      #1;
      chkb("lk_g0", bus.m0_gnt_o, 1'b1);
      chkb("lk_g1", bus.m1_gnt_o, 1'b0);
      chkb("lk_rv0", bus.m0_rvalid_o, 1'b1);
    end
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    slv(1'b1, 1'b1, 32'h210);
    #1;
    chkb("lk_rel_g1", bus.m1_gnt_o, 1'b1);
    chkb("lk_rel_rv0", bus.m0_rvalid_o, 1'b1);
    chkb("lk_rel_to", bus.lock_timeout_o, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    slv(1'b1, 1'b1, 32'h211);
    #1;
    chkb("lk_rv1", bus.m1_rvalid_o, 1'b1);
    chk("lk_d1", bus.m1_data_o, 32'h211);

    // Lock timeout: m0 locks at step 0, m1 waits steps 1..8, revoked and granted at step 9.
    // m0 cannot re-lock (step 11 goes to m1) until lock_i drops at step 12.
    t4_r0 = 16'h6FFF;
    t4_l0 = 16'h6FFF;
    t4_r1 = 16'h4FFF;
    t4_g0 = 16'h65FF;
    t4_g1 = 16'h0A00;
    t4_to = 16'h0200;
    for (int i = 0; i < 16; i++) begin
      tick();
      drive(t4_r0[i], t4_l0[i], t4_r1[i], 1'b0);
      slv(1'b1, 1'b1, 32'h0);
      #1;
      chkb("to_g0", bus.m0_gnt_o, t4_g0[i]);
      chkb("to_g1", bus.m1_gnt_o, t4_g1[i]);
      chkb("to_pulse", bus.lock_timeout_o, t4_to[i]);
    end

    // rvalid delayed 3 cycles with two outstanding: third request stalls until the pop.
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    slv(1'b1, 1'b0, 32'h0);
    #1;
    chkb("of_g0_a", bus.m0_gnt_o, 1'b1);
    tick();
    #1;
    chkb("of_g0_b", bus.m0_gnt_o, 1'b1);
    tick();
    #1;
    chkb("of_stall_sreq", bus.s_req_o, 1'b0);
    chkb("of_stall_g0", bus.m0_gnt_o, 1'b0);
    tick();
    slv(1'b1, 1'b1, 32'h300);
    #1;
    chkb("of_pop_sreq", bus.s_req_o, 1'b1);
    chkb("of_pop_g0", bus.m0_gnt_o, 1'b1);
    chkb("of_pop_rv0", bus.m0_rvalid_o, 1'b1);
    chk("of_pop_d0", bus.m0_data_o, 32'h300);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    slv(1'b1, 1'b1, 32'h301);
    #1;
    chkb("of_rv0_b", bus.m0_rvalid_o, 1'b1);
    tick();
    slv(1'b1, 1'b1, 32'h302);
    #1;
    chkb("of_rv0_c", bus.m0_rvalid_o, 1'b1);

    // Spurious response with the FIFO empty is dropped.
    tick();
    slv(1'b0, 1'b1, 32'h999);
    #1;
    chkb("sp_rv0", bus.m0_rvalid_o, 1'b0);
    chkb("sp_rv1", bus.m1_rvalid_o, 1'b0);
    chk("sp_d0", bus.m0_data_o, 32'h0);
    chk("sp_d1", bus.m1_data_o, 32'h0);

    // Two outstanding, then an asynchronous reset mid-cycle.
    for (int i = 0; i < 2; i++) begin
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      slv(1'b1, 1'b0, 32'h0);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    slv(1'b0, 1'b1, 32'h777);
    #1;
    chkb("ar_pre_rv0", bus.m0_rvalid_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chkb("ar_rv0", bus.m0_rvalid_o, 1'b0);
    chk("ar_d0", bus.m0_data_o, 32'h0);
    chkb("ar_sreq", bus.s_req_o, 1'b0);
    chkb("ar_to", bus.lock_timeout_o, 1'b0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    slv(1'b0, 1'b1, 32'h778);
    #1;
    chkb("post_rst_rv0", bus.m0_rvalid_o, 1'b0);
    chkb("post_rst_rv1", bus.m1_rvalid_o, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    slv(1'b1, 1'b0, 32'h0);
    #1;
    chkb("post_rst_prio_g0", bus.m0_gnt_o, 1'b1);
    chkb("post_rst_prio_g1", bus.m1_gnt_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
